// File: rtl/adxl362_resp_pkg.sv
// Shared constants, types and helpers for the ADXL362 SPI responder.
package adxl362_resp_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned SAMPLE_W    = 12;
    localparam int unsigned NUM_WR_REGS = 15;
    localparam int unsigned WR_IDX_W    = 4;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;

    localparam logic [BYTE_W-1:0] ADDR_DEVID_AD  = 8'h00;
    localparam logic [BYTE_W-1:0] ADDR_DEVID_MST = 8'h01;
    localparam logic [BYTE_W-1:0] ADDR_PARTID    = 8'h02;
    localparam logic [BYTE_W-1:0] ADDR_REVID     = 8'h03;
    localparam logic [BYTE_W-1:0] ADDR_XDATA     = 8'h08;
    localparam logic [BYTE_W-1:0] ADDR_YDATA     = 8'h09;
    localparam logic [BYTE_W-1:0] ADDR_ZDATA     = 8'h0A;
    localparam logic [BYTE_W-1:0] ADDR_STATUS    = 8'h0B;
    localparam logic [BYTE_W-1:0] ADDR_XDATA_L   = 8'h0E;
    localparam logic [BYTE_W-1:0] ADDR_XDATA_H   = 8'h0F;
    localparam logic [BYTE_W-1:0] ADDR_YDATA_L   = 8'h10;
    localparam logic [BYTE_W-1:0] ADDR_YDATA_H   = 8'h11;
    localparam logic [BYTE_W-1:0] ADDR_ZDATA_L   = 8'h12;
    localparam logic [BYTE_W-1:0] ADDR_ZDATA_H   = 8'h13;
    localparam logic [BYTE_W-1:0] ADDR_TEMP_L    = 8'h14;
    localparam logic [BYTE_W-1:0] ADDR_TEMP_H    = 8'h15;
    localparam logic [BYTE_W-1:0] ADDR_SOFT_RST  = 8'h1F;
    localparam logic [BYTE_W-1:0] ADDR_WR_FIRST  = 8'h20;
    localparam logic [BYTE_W-1:0] ADDR_POWER_CTL = 8'h2D;
    localparam logic [BYTE_W-1:0] ADDR_WR_LAST   = 8'h2E;
    localparam logic [BYTE_W-1:0] ADDR_WRAP      = 8'h3F;

    localparam logic [BYTE_W-1:0] DEVID_AD       = 8'hAD;
    localparam logic [BYTE_W-1:0] DEVID_MST      = 8'h1D;
    localparam logic [BYTE_W-1:0] PARTID         = 8'hF2;
    localparam logic [BYTE_W-1:0] REVID          = 8'h01;
    localparam logic [BYTE_W-1:0] STATUS_DEFAULT = 8'h01;
    localparam logic [BYTE_W-1:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [WR_IDX_W-1:0] POWER_CTL_IDX = WR_IDX_W'(ADDR_POWER_CTL - ADDR_WR_FIRST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA
    } spi_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] x;
        logic [SAMPLE_W-1:0] y;
        logic [SAMPLE_W-1:0] z;
        logic [SAMPLE_W-1:0] temp;
    } sample_t;

    function automatic logic [BYTE_W-1:0] lo_byte(input logic [SAMPLE_W-1:0] v);
        return v[7:0];
    endfunction

    // High byte is the top nibble sign-extended to a full byte
    function automatic logic [BYTE_W-1:0] hi_byte(input logic [SAMPLE_W-1:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

    function automatic logic is_data_addr(input logic [BYTE_W-1:0] a);
        return (a >= ADDR_XDATA && a <= ADDR_ZDATA) || (a >= ADDR_XDATA_L && a <= ADDR_TEMP_H);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizers for the SPI pins plus registered SCLK/SS edge pulses.
module spi_edge_sync (
    input  logic sysclk,
    input  logic sysreset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_active,
    output logic mosi_bit
);

    // [0],[1] are the synchronizer, [2] holds history for edge detection
    logic [2:0] sck_sr;
    logic [2:0] ss_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            sck_sr    <= '0;
            ss_sr     <= '1;
            mosi_sr   <= '0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
            ss_active <= 1'b0;
            mosi_bit  <= 1'b0;
        end else begin
            sck_sr    <= {sck_sr[1:0], sck};
            ss_sr     <= {ss_sr[1:0], ss};
            mosi_sr   <= {mosi_sr[0], mosi};
            sck_rise  <= sck_sr[1] & ~sck_sr[2];
            sck_fall  <= ~sck_sr[1] & sck_sr[2];
            ss_fall   <= ~ss_sr[1] & ss_sr[2];
            ss_rise   <= ss_sr[1] & ~ss_sr[2];
            ss_active <= ~ss_sr[1];
            mosi_bit  <= mosi_sr[1];
        end
    end

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362-style SPI register responder running in the sysclk domain.
// Define ADXL362_RESP_STATUS_EN to get a live DATA_READY bit in STATUS (0x0B).
module adxl362_spi_responder
    import adxl362_resp_pkg::*;
(
    input  logic                sysclk,
    input  logic                sysreset,
    input  logic                aclSCK,
    input  logic                aclSS,
    input  logic                aclMOSI,
    output logic                aclMISO,
    input  logic [SAMPLE_W-1:0] accel_x,
    input  logic [SAMPLE_W-1:0] accel_y,
    input  logic [SAMPLE_W-1:0] accel_z,
    input  logic [SAMPLE_W-1:0] temp,
    input  logic                sample_valid,
    output logic                measure_en,
    output logic                cmd_err
);

    logic sck_rise, sck_fall, ss_fall, ss_rise, ss_active, mosi_bit;

    spi_edge_sync u_edge_sync (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .sck       (aclSCK),
        .ss        (aclSS),
        .mosi      (aclMOSI),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .ss_active (ss_active),
        .mosi_bit  (mosi_bit)
    );

    spi_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [BYTE_W-1:0] shift_q, cmd_q, addr_q, tx_q;
    logic [BYTE_W-1:0] wr_regs_q [NUM_WR_REGS];
    sample_t           live_q, snap_q, sample_in;

    logic [BYTE_W-1:0] rx_byte_c, addr_inc_c, rd_addr_c, rd_byte_c, status_byte_c;
    logic              byte_done_c, is_read_c, is_write_c, load_c, commit_c;
    logic              cmd_err_c, miso_d;

    assign sample_in   = '{x: accel_x, y: accel_y, z: accel_z, temp: temp};
    assign rx_byte_c   = {shift_q[6:0], mosi_bit};
    assign byte_done_c = sck_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
    assign is_read_c   = (cmd_q == CMD_READ);
    assign is_write_c  = (cmd_q == CMD_WRITE);
    assign addr_inc_c  = (addr_q == ADDR_WRAP) ? '0 : addr_q + 8'd1;
    assign rd_addr_c   = (state_q == ST_ADDR) ? rx_byte_c : addr_inc_c;
    assign load_c      = byte_done_c && is_read_c && (state_q == ST_ADDR || state_q == ST_DATA);
    assign commit_c    = byte_done_c && is_write_c && (state_q == ST_DATA);

`ifdef ADXL362_RESP_STATUS_EN
    logic data_ready_q;

    // A new sample wins over a simultaneous data read
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            data_ready_q <= 1'b0;
        end else if (sample_valid) begin
            data_ready_q <= 1'b1;
        end else if (load_c && is_data_addr(rd_addr_c)) begin
            data_ready_q <= 1'b0;
        end
    end

    assign status_byte_c = {7'd0, data_ready_q};
`else
    assign status_byte_c = STATUS_DEFAULT;
`endif

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_err_c = 1'b0;
        miso_d    = 1'b0;
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (ss_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done_c) begin
                        state_d   = ST_ADDR;
                        cmd_err_c = (rx_byte_c != CMD_READ) && (rx_byte_c != CMD_WRITE);
                    end
                end
                ST_ADDR: if (byte_done_c) state_d = ST_DATA;
                ST_DATA: state_d = ST_DATA;
                default: state_d = ST_IDLE;
            endcase
        end
        if (ss_active && state_q == ST_DATA && is_read_c) begin
            miso_d = sck_fall ? tx_q[7] : aclMISO;
        end
    end

    always_comb begin
        rd_byte_c = '0;
        case (rd_addr_c)
            ADDR_DEVID_AD:  rd_byte_c = DEVID_AD;
            ADDR_DEVID_MST: rd_byte_c = DEVID_MST;
            ADDR_PARTID:    rd_byte_c = PARTID;
            ADDR_REVID:     rd_byte_c = REVID;
            ADDR_XDATA:     rd_byte_c = snap_q.x[11:4];
            ADDR_YDATA:     rd_byte_c = snap_q.y[11:4];
            ADDR_ZDATA:     rd_byte_c = snap_q.z[11:4];
            ADDR_STATUS:    rd_byte_c = status_byte_c;
            ADDR_XDATA_L:   rd_byte_c = lo_byte(snap_q.x);
            ADDR_XDATA_H:   rd_byte_c = hi_byte(snap_q.x);
            ADDR_YDATA_L:   rd_byte_c = lo_byte(snap_q.y);
            ADDR_YDATA_H:   rd_byte_c = hi_byte(snap_q.y);
            ADDR_ZDATA_L:   rd_byte_c = lo_byte(snap_q.z);
            ADDR_ZDATA_H:   rd_byte_c = hi_byte(snap_q.z);
            ADDR_TEMP_L:    rd_byte_c = lo_byte(snap_q.temp);
            ADDR_TEMP_H:    rd_byte_c = hi_byte(snap_q.temp);
            default: begin
                if (rd_addr_c >= ADDR_WR_FIRST && rd_addr_c <= ADDR_WR_LAST) begin
                    rd_byte_c = wr_regs_q[WR_IDX_W'(rd_addr_c - ADDR_WR_FIRST)];
                end
            end
        endcase
    end

    // Bit/byte assembly, address tracking and read shifter
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            aclMISO    <= 1'b0;
            cmd_err    <= 1'b0;
            measure_en <= 1'b0;
        end else begin
            if (ss_fall) begin
                bit_cnt_q <= '0;
            end else if (sck_rise && state_q != ST_IDLE) begin
                shift_q   <= rx_byte_c;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (state_q == ST_CMD && byte_done_c) begin
                cmd_q <= rx_byte_c;
            end
            if (state_q == ST_ADDR && byte_done_c) begin
                addr_q <= rx_byte_c;
            end else if (state_q == ST_DATA && byte_done_c) begin
                addr_q <= addr_inc_c;
            end
            if (load_c) begin
                tx_q <= rd_byte_c;
            end else if (sck_fall) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
            aclMISO    <= miso_d;
            cmd_err    <= cmd_err_c;
            measure_en <= (wr_regs_q[POWER_CTL_IDX][1:0] == 2'b10);
        end
    end

    // Writable register file; soft reset clears it on the committing cycle
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            for (int i = 0; i < NUM_WR_REGS; i++) wr_regs_q[i] <= '0;
        end else if (commit_c) begin
            if (addr_q == ADDR_SOFT_RST && rx_byte_c == SOFT_RESET_KEY) begin
                for (int i = 0; i < NUM_WR_REGS; i++) wr_regs_q[i] <= '0;
            end else if (addr_q >= ADDR_WR_FIRST && addr_q <= ADDR_WR_LAST) begin
                wr_regs_q[WR_IDX_W'(addr_q - ADDR_WR_FIRST)] <= rx_byte_c;
            end
        end
    end

    // Snapshot takes a coincident new sample rather than the stale live set
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            live_q <= '0;
            snap_q <= '0;
        end else begin
            if (sample_valid) live_q <= sample_in;
            if (ss_fall) snap_q <= sample_valid ? sample_in : live_q;
        end
    end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed self-checking bench for adxl362_spi_responder driving SPI mode 0.
module tb_adxl362_spi_responder;

    localparam int HALF = 8;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic        aclSCK, aclSS, aclMOSI;
    logic        aclMISO;
    logic [11:0] accel_x, accel_y, accel_z, temp;
    logic        sample_valid;
    logic        measure_en, cmd_err;

    int checks = 0;
    int errors = 0;
    int cmd_err_cnt = 0;
    int miso_ones = 0;
    logic miso_mon_en = 1'b0;

    adxl362_spi_responder dut (
        .sysclk       (sysclk),
        .sysreset     (sysreset),
        .aclSCK       (aclSCK),
        .aclSS        (aclSS),
        .aclMOSI      (aclMOSI),
        .aclMISO      (aclMISO),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .temp         (temp),
        .sample_valid (sample_valid),
        .measure_en   (measure_en),
        .cmd_err      (cmd_err)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (cmd_err === 1'b1) cmd_err_cnt++;
        if (miso_mon_en && aclMISO !== 1'b0) miso_ones++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            aclMOSI = tx[7-i];
            wait_cyc(HALF);
            rx = {rx[6:0], aclMISO};
            aclSCK = 1'b1;
            wait_cyc(HALF);
            aclSCK = 1'b0;
        end
    endtask

    task automatic ss_begin();
        aclSS = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic ss_end();
        wait_cyc(HALF);
        aclSS   = 1'b1;
        aclMOSI = 1'b0;
        wait_cyc(4 * HALF);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        ss_begin();
        xfer(8'h0A, 8, r);
        xfer(a, 8, r);
        xfer(d, 8, r);
        ss_end();
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] r;
        ss_begin();
        xfer(8'h0B, 8, r);
        xfer(a, 8, r);
        xfer(8'h00, 8, d);
        ss_end();
    endtask

    task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y);
        accel_x      = x;
        accel_y      = y;
        sample_valid = 1'b1;
        wait_cyc(1);
        sample_valid = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        logic [7:0] r, d;
        logic [7:0] burst [5];
        logic [7:0] exp_id [5];
        int         errs_before;

        exp_id[0] = 8'hAD; exp_id[1] = 8'h1D; exp_id[2] = 8'hF2;
        exp_id[3] = 8'h01; exp_id[4] = 8'h00;

        sysreset = 1'b0;
        aclSCK = 1'b0; aclSS = 1'b1; aclMOSI = 1'b0;
        accel_x = '0; accel_y = '0; accel_z = '0; temp = '0;
        sample_valid = 1'b0;
        wait_cyc(5);
        check("reset_miso", 8'(aclMISO), 8'h00);
        check("reset_cmd_err", 8'(cmd_err), 8'h00);
        check("reset_measure_en", 8'(measure_en), 8'h00);
        sysreset = 1'b1;
        wait_cyc(5);

        // ID burst from 0x00, fifth byte is unmapped 0x04
        ss_begin();
        xfer(8'h0B, 8, r);
        xfer(8'h00, 8, r);
        for (int i = 0; i < 5; i++) xfer(8'h00, 8, burst[i]);
        ss_end();
        for (int i = 0; i < 5; i++) check($sformatf("id_burst[%0d]", i), burst[i], exp_id[i]);

        write_reg(8'h2D, 8'h02);
        check("measure_en_on", 8'(measure_en), 8'h01);
        read_reg(8'h2D, d);
        check("power_ctl_rb", d, 8'h02);

        write_reg(8'h20, 8'h5A);
        read_reg(8'h20, d);
        check("reg20_rb", d, 8'h5A);
        write_reg(8'h30, 8'hFF);
        read_reg(8'h30, d);
        check("unmapped_write_ignored", d, 8'h00);

        // Address wrap 0x3F -> 0x00
        ss_begin();
        xfer(8'h0B, 8, r);
        xfer(8'h3F, 8, r);
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        ss_end();
        check("wrap_3f", burst[0], 8'h00);
        check("wrap_00", burst[1], 8'hAD);

        // Sample data formatting
        pulse_sample(12'h7F3, 12'h000);
        ss_begin();
        xfer(8'h0B, 8, r);
        xfer(8'h0E, 8, r);
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        ss_end();
        check("x_lo_7f3", burst[0], 8'hF3);
        check("x_hi_7f3", burst[1], 8'h07);
        pulse_sample(12'h803, 12'h000);
        ss_begin();
        xfer(8'h0B, 8, r);
        xfer(8'h0E, 8, r);
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        ss_end();
        check("x_lo_803", burst[0], 8'h03);
        check("x_hi_803", burst[1], 8'hF8);
        read_reg(8'h08, d);
        check("xdata_803", d, 8'h80);

        // Snapshot holds across a mid-transaction sample
        pulse_sample(12'h803, 12'h123);
        ss_begin();
        xfer(8'h0B, 8, r);
        pulse_sample(12'h456, 12'hABC);
        xfer(8'h10, 8, r);
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        ss_end();
        check("snap_y_lo", burst[0], 8'h23);
        check("snap_y_hi", burst[1], 8'h01);
        read_reg(8'h11, d);
        check("live_y_hi", d, 8'hFA);

`ifdef ADXL362_RESP_STATUS_EN
        pulse_sample(12'h001, 12'h002);
        read_reg(8'h0B, d);
        check("status_ready", d, 8'h01);
        read_reg(8'h08, d);
        read_reg(8'h0B, d);
        check("status_cleared", d, 8'h00);
`else
        read_reg(8'h0B, d);
        check("status_const", d, 8'h01);
`endif

        // Partial data byte is discarded
        ss_begin();
        xfer(8'h0A, 8, r);
        xfer(8'h2D, 8, r);
        xfer(8'hFF, 5, r);
        ss_end();
        read_reg(8'h2D, d);
        check("partial_write", d, 8'h02);

        write_reg(8'h1F, 8'h52);
        check("soft_reset_measure", 8'(measure_en), 8'h00);
        read_reg(8'h2D, d);
        check("soft_reset_2d", d, 8'h00);
        read_reg(8'h20, d);
        check("soft_reset_20", d, 8'h00);

        // Unknown command
        errs_before = cmd_err_cnt;
        miso_ones   = 0;
        miso_mon_en = 1'b1;
        ss_begin();
        xfer(8'h55, 8, r);
        xfer(8'h00, 8, r);
        xfer(8'h00, 8, burst[0]);
        xfer(8'h00, 8, burst[1]);
        ss_end();
        miso_mon_en = 1'b0;
        check("bad_cmd_pulses", 8'(cmd_err_cnt - errs_before), 8'h01);
        check("bad_cmd_miso", 8'(miso_ones), 8'h00);

        // Reset in the middle of a read
        write_reg(8'h2D, 8'h02);
        check("measure_en_again", 8'(measure_en), 8'h01);
        ss_begin();
        xfer(8'h0B, 8, r);
        xfer(8'h00, 8, r);
        xfer(8'h00, 2, r);
        wait_cyc(HALF);
        check("pre_reset_miso", 8'(aclMISO), 8'h01);
        sysreset = 1'b0;
        wait_cyc(3);
        check("midread_reset_miso", 8'(aclMISO), 8'h00);
        check("midread_reset_measure", 8'(measure_en), 8'h00);
        aclSS   = 1'b1;
        aclMOSI = 1'b0;
        wait_cyc(4);
        sysreset = 1'b1;
        wait_cyc(4 * HALF);
        read_reg(8'h01, d);
        check("post_reset_read", d, 8'h1D);
        read_reg(8'h2D, d);
        check("post_reset_2d", d, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
